// File: rtl/hf_reader_seq_pkg.sv
// rtl/hf_reader_seq_pkg.sv - ISO14443-A mode codes and reader sequencer state encodings
package hf_reader_seq_pkg;

  localparam logic [2:0] MODE_SNIFFER       = 3'b000;
  localparam logic [2:0] MODE_TAGSIM_LISTEN = 3'b001;
  localparam logic [2:0] MODE_TAGSIM_MOD    = 3'b010;
  localparam logic [2:0] MODE_READER_LISTEN = 3'b011;
  localparam logic [2:0] MODE_READER_MOD    = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TX     = 2'd1,
    ST_GAP    = 2'd2,
    ST_LISTEN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/hf_reader_seq_if.sv
// rtl/hf_reader_seq_if.sv - control/status bundle between the ARM-side logic and the reader sequencer
interface hf_reader_seq_if #(
  parameter int CNT_W = 16
);
  logic             conf_wr;
  logic [7:0]       conf_word;
  logic             pause_in;
  logic             bit_strobe;
  logic             curbit;
  logic [2:0]       mod_type;
  logic             mod_sig;
  logic             busy;
  logic [CNT_W-1:0] fdt_count;
  logic             fdt_valid;
  logic             timeout;

  modport master (
    output conf_wr, conf_word, pause_in, bit_strobe, curbit,
    input  mod_type, mod_sig, busy, fdt_count, fdt_valid, timeout
  );

  modport slave (
    input  conf_wr, conf_word, pause_in, bit_strobe, curbit,
    output mod_type, mod_sig, busy, fdt_count, fdt_valid, timeout
  );
endinterface

// File: rtl/hf_reader_seq_pause_edge.sv
// rtl/hf_reader_seq_pause_edge.sv - hf_pause_edge: registers pause_in, drives mod_sig, flags pause edges
module hf_pause_edge (
  input  logic ck_1356meg,
  input  logic nrst,
  input  logic pause_in,
  input  logic mod_en,
  output logic mod_sig,
  output logic pause_rise,
  output logic pause_fall
);

  logic pause_q;

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      pause_q <= 1'b0;
      mod_sig <= 1'b0;
    end else begin
      pause_q <= pause_in;
      mod_sig <= pause_in & mod_en;
    end
  end

  // Edges are flagged in the cycle pause_in changes, one cycle ahead of mod_sig.
  assign pause_rise = pause_in & ~pause_q;
  assign pause_fall = ~pause_in & pause_q;

endmodule

// File: rtl/hf_reader_seq.sv
// rtl/hf_reader_seq.sv - ISO14443-A reader frame sequencer (TX/GAP/LISTEN, FDT capture)
// Optional HF_SEQ_TIMEOUT_EN: enables the LISTEN response timeout pulse.
module hf_reader_seq
  import hf_reader_seq_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int EOF_CYC     = 320,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic           ck_1356meg,
  input  logic           nrst,
  hf_reader_seq_if.slave bus
);

`ifdef HF_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  seq_state_e       state;
  logic [2:0]       mod_type_q;
  logic             busy_q;
  logic [CNT_W-1:0] fdt_cnt;
  logic [CNT_W-1:0] quiet_cnt;
  logic [CNT_W-1:0] fdt_count_q;
  logic             fdt_valid_q;
  logic             timeout_q;

  logic pause_rise;
  logic pause_fall;
  logic mod_en;
  logic auto_req;
  logic response;
  logic tmo_hit;
  logic conf_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign auto_req    = bus.conf_word[3] && (bus.conf_word[2:0] == MODE_READER_MOD);
  assign response    = bus.bit_strobe && bus.curbit;
  assign tmo_hit     = TMO_EN && (fdt_cnt == TMO_LAST);
  assign conf_unused = ^bus.conf_word[7:4];

  // mod_sig is gated by the state the FSM is about to enter, so a new frame
  // starting from LISTEN drives the coil on its first pause cycle.
  always_comb begin
    mod_en = 1'b0;
    if (bus.conf_wr) begin
      mod_en = auto_req;
    end else begin
      case (state)
        ST_TX, ST_GAP: mod_en = 1'b1;
        ST_LISTEN:     mod_en = pause_rise;
        default:       mod_en = 1'b0;
      endcase
    end
  end

  hf_pause_edge u_pause_edge (
    .ck_1356meg (ck_1356meg),
    .nrst       (nrst),
    .pause_in   (bus.pause_in),
    .mod_en     (mod_en),
    .mod_sig    (bus.mod_sig),
    .pause_rise (pause_rise),
    .pause_fall (pause_fall)
  );

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      mod_type_q  <= MODE_SNIFFER;
      busy_q      <= 1'b0;
      fdt_cnt     <= '0;
      quiet_cnt   <= '0;
      fdt_count_q <= '0;
      fdt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (bus.conf_wr) begin
        if (auto_req) begin
          state       <= ST_TX;
          mod_type_q  <= MODE_READER_MOD;
          busy_q      <= 1'b1;
          fdt_valid_q <= 1'b0;
        end else begin
          state      <= ST_IDLE;
          mod_type_q <= bus.conf_word[2:0];
          busy_q     <= 1'b0;
        end
      end else begin
        case (state)
          ST_TX: begin
            // The fall cycle itself is count 0, so the next cycle reads 1.
            if (pause_fall) begin
              fdt_cnt   <= CNT_W'(1);
              quiet_cnt <= CNT_W'(1);
              state     <= ST_GAP;
            end
          end
          ST_GAP: begin
            fdt_cnt   <= sat_inc(fdt_cnt);
            quiet_cnt <= sat_inc(quiet_cnt);
            if (bus.pause_in) begin
              state <= ST_TX;
            end else if (quiet_cnt == EOF_LAST) begin
              state      <= ST_LISTEN;
              mod_type_q <= MODE_READER_LISTEN;
            end
          end
          ST_LISTEN: begin
            fdt_cnt <= sat_inc(fdt_cnt);
            if (pause_rise) begin
              state       <= ST_TX;
              mod_type_q  <= MODE_READER_MOD;
              fdt_valid_q <= 1'b0;
            end else if (response) begin
              fdt_count_q <= fdt_cnt;
              fdt_valid_q <= 1'b1;
              state       <= ST_IDLE;
              busy_q      <= 1'b0;
            end else if (tmo_hit) begin
              timeout_q <= 1'b1;
              state     <= ST_IDLE;
              busy_q    <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mod_type  = mod_type_q;
  assign bus.busy      = busy_q;
  assign bus.fdt_count = fdt_count_q;
  assign bus.fdt_valid = fdt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_hf_reader_seq.sv
// tb/tb_hf_reader_seq.sv - directed self-checking bench for hf_reader_seq
module tb_hf_reader_seq;

  logic clk;
  logic nrst;
  int   errors = 0;
  int   checks = 0;

  hf_reader_seq_if #(.CNT_W(16)) bus ();

  hf_reader_seq #(
    .CNT_W       (16),
    .EOF_CYC     (320),
    .TIMEOUT_CYC (4096)
  ) dut (
    .ck_1356meg (clk),
    .nrst       (nrst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic conf(input logic [7:0] w);
    bus.conf_wr   = 1'b1;
    bus.conf_word = w;
    tick();
    bus.conf_wr   = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mod_type"},  32'(bus.mod_type),  32'h0);
    chk({tag, "_mod_sig"},   32'(bus.mod_sig),   32'h0);
    chk({tag, "_busy"},      32'(bus.busy),      32'h0);
    chk({tag, "_fdt_count"}, 32'(bus.fdt_count), 32'h0);
    chk({tag, "_fdt_valid"}, 32'(bus.fdt_valid), 32'h0);
    chk({tag, "_timeout"},   32'(bus.timeout),   32'h0);
  endtask

  initial begin
    nrst           = 1'b0;
    bus.conf_wr    = 1'b0;
    bus.conf_word  = 8'h00;
    bus.pause_in   = 1'b0;
    bus.bit_strobe = 1'b0;
    bus.curbit     = 1'b0;
    ticks(2);
    chk_reset_outputs("reset");
    nrst = 1'b1;
    tick();

    // Manual mode select
    conf(8'h03);
    chk("manual_mod_type", 32'(bus.mod_type), 32'h3);
    chk("manual_busy",     32'(bus.busy),     32'h0);

    // Auto frame: 40 pause cycles, gap, LISTEN, response at 1180
    conf(8'h0C);
    chk("tx_mod_type", 32'(bus.mod_type), 32'h4);
    chk("tx_busy",     32'(bus.busy),     32'h1);
    chk("tx_mod_sig0", 32'(bus.mod_sig),  32'h0);
    bus.pause_in = 1'b1;
    tick();
    chk("tx_mod_sig_lag", 32'(bus.mod_sig), 32'h1);
    ticks(39);
    bus.pause_in = 1'b0;
    chk("fall_mod_sig_still_high", 32'(bus.mod_sig), 32'h1);
    tick();
    chk("gap_mod_sig_low", 32'(bus.mod_sig), 32'h0);
    ticks(99);
    bus.bit_strobe = 1'b1;
    bus.curbit     = 1'b1;
    tick();
    bus.bit_strobe = 1'b0;
    bus.curbit     = 1'b0;
    chk("gap_curbit_ignored_valid", 32'(bus.fdt_valid), 32'h0);
    chk("gap_curbit_ignored_mode",  32'(bus.mod_type),  32'h4);
    chk("gap_curbit_ignored_busy",  32'(bus.busy),      32'h1);
    ticks(218);
    chk("eof_minus1_mod_type", 32'(bus.mod_type), 32'h4);
    tick();
    chk("eof_mod_type", 32'(bus.mod_type), 32'h3);
    chk("eof_busy",     32'(bus.busy),     32'h1);
    ticks(860);
    bus.bit_strobe = 1'b1;
    bus.curbit     = 1'b1;
    tick();
    bus.bit_strobe = 1'b0;
    bus.curbit     = 1'b0;
    chk("resp_fdt_count", 32'(bus.fdt_count), 32'd1180);
    chk("resp_fdt_valid", 32'(bus.fdt_valid), 32'h1);
    chk("resp_busy",      32'(bus.busy),      32'h0);
    chk("resp_mod_type",  32'(bus.mod_type),  32'h3);

    // No response
    conf(8'h0C);
    chk("auto_clears_valid", 32'(bus.fdt_valid), 32'h0);
    bus.pause_in = 1'b1;
    ticks(5);
    bus.pause_in = 1'b0;
    ticks(4095);
    chk("tmo_not_early", 32'(bus.timeout), 32'h0);
    tick();
`ifdef HF_SEQ_TIMEOUT_EN
    chk("tmo_pulse",      32'(bus.timeout), 32'h1);
    chk("tmo_busy",       32'(bus.busy),    32'h0);
    tick();
    chk("tmo_one_cycle",  32'(bus.timeout), 32'h0);
`else
    chk("tmo_disabled",   32'(bus.timeout), 32'h0);
    chk("tmo_dis_busy",   32'(bus.busy),    32'h1);
    ticks(100);
    chk("tmo_dis_busy2",  32'(bus.busy),    32'h1);
    chk("tmo_dis_mode",   32'(bus.mod_type), 32'h3);
`endif

    // Pause returns after 200 quiet cycles
    conf(8'h0C);
    bus.pause_in = 1'b1;
    ticks(10);
    bus.pause_in = 1'b0;
    ticks(200);
    bus.pause_in = 1'b1;
    tick();
    chk("regap_mod_type", 32'(bus.mod_type), 32'h4);
    chk("regap_mod_sig",  32'(bus.mod_sig),  32'h1);
    chk("regap_busy",     32'(bus.busy),     32'h1);
    ticks(2);
    bus.pause_in = 1'b0;
    ticks(319);
    chk("restart_eof_minus1", 32'(bus.mod_type), 32'h4);
    tick();
    chk("restart_eof", 32'(bus.mod_type), 32'h3);

    // conf_wr beats a coincident response
    ticks(5);
    bus.conf_wr    = 1'b1;
    bus.conf_word  = 8'h00;
    bus.bit_strobe = 1'b1;
    bus.curbit     = 1'b1;
    tick();
    bus.conf_wr    = 1'b0;
    bus.bit_strobe = 1'b0;
    bus.curbit     = 1'b0;
    chk("abort_mod_type",  32'(bus.mod_type),  32'h0);
    chk("abort_fdt_valid", 32'(bus.fdt_valid), 32'h0);
    chk("abort_busy",      32'(bus.busy),      32'h0);
    chk("abort_fdt_count", 32'(bus.fdt_count), 32'd1180);

    // New pause beats a coincident response in LISTEN
    conf(8'h0C);
    bus.pause_in = 1'b1;
    ticks(5);
    bus.pause_in = 1'b0;
    ticks(330);
    bus.pause_in   = 1'b1;
    bus.bit_strobe = 1'b1;
    bus.curbit     = 1'b1;
    tick();
    bus.bit_strobe = 1'b0;
    bus.curbit     = 1'b0;
    chk("rise_mod_type",  32'(bus.mod_type),  32'h4);
    chk("rise_busy",      32'(bus.busy),      32'h1);
    chk("rise_fdt_valid", 32'(bus.fdt_valid), 32'h0);
    chk("rise_mod_sig",   32'(bus.mod_sig),   32'h1);

    // Asynchronous reset mid-TX
    tick();
    #2;
    nrst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    bus.pause_in = 1'b0;
    nrst = 1'b1;
    tick();
    chk("post_rst_mod_type", 32'(bus.mod_type), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
